ram_linear_search_ctrl: RTL and testbench

RAM_LINEAR_SEARCH_CTRL -- requirements
Module: ram_linear_search_ctrl

---
 rtl/ls_pkg.sv | 16 +
 rtl/ls_cmp_stage.sv | 83 ++++++++
 rtl/ram_linear_search_ctrl.sv | 139 +++++++++++++
 tb/tb_ram_linear_search_ctrl.sv | 196 +++++++++++++++++++
 4 files changed

// File: rtl/ls_pkg.sv
// Shared definitions for the RAM linear-search controller.
//   - default address/data widths and entry count
//   - FSM state encoding (LS_IDLE, LS_SCAN, LS_DONE)
package ls_pkg;

  localparam int LS_A_DEF = 8;
  localparam int LS_D_DEF = 8;
  localparam int LS_R_DEF = 256;

  typedef enum logic [1:0] {
    LS_IDLE = 2'd0,
    LS_SCAN = 2'd1,
    LS_DONE = 2'd2
  } ls_state_e;

endpackage

// File: rtl/ls_cmp_stage.sv
// Compare stage of the linear search.
// It tracks which address the RAM is returning on ram_q (one cycle behind
// the issue side), compares that data against the latched key and captures
// the lowest matching address.
// Optional feature macro: LS_MATCH_COUNT_EN (adds a saturating match counter).
// Ports:
//   clk, rst        clock, synchronous active-high reset
//   clear           accepted start: drop the pipeline and clear results
//   issue_en        an address is being issued to the RAM this cycle
//   issue_addr      address being issued
//   scan            FSM is in SCAN; compares outside SCAN are ignored
//   ram_q, key      RAM read data and latched search key
//   hit             current compare matches
//   cmp_last        current compare is for address R-1
//   found, index    captured result (lowest matching address)
//   match_cnt       total matches, saturating at R (LS_MATCH_COUNT_EN only)
module ls_cmp_stage
  import ls_pkg::*;
#(
  parameter int A = LS_A_DEF,
  parameter int D = LS_D_DEF,
  parameter int R = LS_R_DEF
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clear,
  input  logic         issue_en,
  input  logic [A-1:0] issue_addr,
  input  logic         scan,
  input  logic [D-1:0] ram_q,
  input  logic [D-1:0] key,
  output logic         hit,
  output logic         cmp_last,
  output logic         found,
  output logic [A-1:0] index
`ifdef LS_MATCH_COUNT_EN
  ,output logic [A:0]  match_cnt
`endif
);

  localparam logic [A-1:0] LAST_ADDR = A'(R - 1);

  logic         cmp_valid;
  logic [A-1:0] cmp_addr;

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      cmp_valid <= 1'b0;
      cmp_addr  <= '0;
    end else begin
      cmp_valid <= issue_en;
      cmp_addr  <= issue_addr;
    end
  end

  // scan gating keeps a trailing compare (issued in the last SCAN cycle)
  // from being evaluated during DONE, when the RAM is not enabled.
  assign hit      = cmp_valid && scan && (ram_q == key);
  assign cmp_last = cmp_valid && scan && (cmp_addr == LAST_ADDR);

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      found <= 1'b0;
      index <= '0;
    end else if (hit && !found) begin
      found <= 1'b1;
      index <= cmp_addr;
    end
  end

`ifdef LS_MATCH_COUNT_EN
  localparam logic [A:0] CNT_MAX = (A+1)'(R);

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      match_cnt <= '0;
    end else if (hit && (match_cnt != CNT_MAX)) begin
      match_cnt <= match_cnt + 1'b1;
    end
  end
`endif

endmodule

// File: rtl/ram_linear_search_ctrl.sv
// Linear search controller for an external single-port synchronous RAM.
// The host loads the RAM through wr_* while idle; a start pulse scans
// addresses 0..R-1 looking for key and reports the lowest matching address.
// Optional feature macro: LS_MATCH_COUNT_EN -- scan always covers the whole
// RAM and match_cnt reports the total number of matching entries.
// Ports:
//   clk, rst                       clock, synchronous active-high reset
//   wr_en, wr_addr, wr_data        host write request (honoured in IDLE)
//   start, key                     search request pulse and key
//   busy, done                     search in progress / one-cycle completion
//   found, index                   match flag and lowest matching address
//   ram_ce, ram_we, ram_addr, ram_data, ram_q   external RAM port
//   match_cnt                      total matches (LS_MATCH_COUNT_EN only)
//
// state   | meaning
// --------+---------------------------------------------------------
// LS_IDLE | waiting; host writes pass straight through to the RAM
// LS_SCAN | issuing read addresses, compare stage trails by one cycle
// LS_DONE | one-cycle done pulse, RAM disabled, then back to idle
module ram_linear_search_ctrl
  import ls_pkg::*;
#(
  parameter int A = LS_A_DEF,
  parameter int D = LS_D_DEF,
  parameter int R = LS_R_DEF
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         wr_en,
  input  logic [A-1:0] wr_addr,
  input  logic [D-1:0] wr_data,
  input  logic         start,
  input  logic [D-1:0] key,
  output logic         busy,
  output logic         done,
  output logic         found,
  output logic [A-1:0] index,
  output logic         ram_ce,
  output logic         ram_we,
  output logic [A-1:0] ram_addr,
  output logic [D-1:0] ram_data,
  input  logic [D-1:0] ram_q
`ifdef LS_MATCH_COUNT_EN
  ,output logic [A:0]  match_cnt
`endif
);

  localparam logic [A-1:0] LAST_ADDR = A'(R - 1);

  ls_state_e    state, state_nxt;
  logic [A-1:0] issue_cnt;
  logic [D-1:0] key_q;
  logic         start_acc;
  logic         scan;
  logic         hit;
  logic         cmp_last;

  assign scan = (state == LS_SCAN);

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= LS_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    start_acc = 1'b0;
    busy      = 1'b0;
    done      = 1'b0;
    ram_ce    = 1'b0;
    ram_we    = 1'b0;
    ram_addr  = '0;
    ram_data  = '0;
    unique case (state)
      LS_IDLE: begin
        // Reset is gated in so a held write cannot reach the RAM during reset.
        if (wr_en && !rst) begin
          ram_ce   = 1'b1;
          ram_we   = 1'b1;
          ram_addr = wr_addr;
          ram_data = wr_data;
        end else if (start) begin
          start_acc = 1'b1;
          state_nxt = LS_SCAN;
        end
      end
      LS_SCAN: begin
        busy     = 1'b1;
        ram_ce   = 1'b1;
        ram_addr = issue_cnt;
`ifdef LS_MATCH_COUNT_EN
        if (cmp_last) state_nxt = LS_DONE;
`else
        if (hit || cmp_last) state_nxt = LS_DONE;
`endif
      end
      LS_DONE: begin
        busy      = 1'b1;
        done      = 1'b1;
        state_nxt = LS_IDLE;
      end
      default: state_nxt = LS_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      issue_cnt <= '0;
      key_q     <= '0;
    end else if (start_acc) begin
      issue_cnt <= '0;
      key_q     <= key;
    end else if (scan && (issue_cnt != LAST_ADDR)) begin
      issue_cnt <= issue_cnt + 1'b1;
    end
  end

  ls_cmp_stage #(.A(A), .D(D), .R(R)) u_cmp (
    .clk        (clk),
    .rst        (rst),
    .clear      (start_acc),
    .issue_en   (scan),
    .issue_addr (issue_cnt),
    .scan       (scan),
    .ram_q      (ram_q),
    .key        (key_q),
    .hit        (hit),
    .cmp_last   (cmp_last),
    .found      (found),
    .index      (index)
`ifdef LS_MATCH_COUNT_EN
    ,.match_cnt (match_cnt)
`endif
  );

endmodule

// File: tb/tb_ram_linear_search_ctrl.sv
module tb_ram_linear_search_ctrl;

`ifdef LS_MATCH_COUNT_EN
  localparam bit COUNT_MODE = 1'b1;
`else
  localparam bit COUNT_MODE = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst;
  logic       wr_en;
  logic [7:0] wr_addr;
  logic [7:0] wr_data;
  logic       start;
  logic [7:0] key;
  logic       busy, done, found;
  logic [7:0] index;
  logic       ram_ce, ram_we;
  logic [7:0] ram_addr, ram_data;
  logic [7:0] ram_q;
`ifdef LS_MATCH_COUNT_EN
  logic [8:0] match_cnt;
`endif

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  ram_linear_search_ctrl #(.A(8), .D(8), .R(256)) dut (
    .clk      (clk),
    .rst      (rst),
    .wr_en    (wr_en),
    .wr_addr  (wr_addr),
    .wr_data  (wr_data),
    .start    (start),
    .key      (key),
    .busy     (busy),
    .done     (done),
    .found    (found),
    .index    (index),
    .ram_ce   (ram_ce),
    .ram_we   (ram_we),
    .ram_addr (ram_addr),
    .ram_data (ram_data),
    .ram_q    (ram_q)
`ifdef LS_MATCH_COUNT_EN
    ,.match_cnt (match_cnt)
`endif
  );

  // Behavioural single-port synchronous RAM
  logic [7:0] mem [256];
  always @(posedge clk) begin
    if (ram_ce) begin
      if (ram_we) mem[ram_addr] <= ram_data;
      else        ram_q <= mem[ram_addr];
    end
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic load(input logic [7:0] a, input logic [7:0] d);
    wr_en = 1'b1; wr_addr = a; wr_data = d;
    tick;
    wr_en = 1'b0;
  endtask

  // Start a search and count rising edges from the start-accepting edge to
  // the one after which done is high. hold_req keeps start and a write to
  // address 42 asserted during the scan; both must be ignored while busy.
  task automatic run_search(input string tag, input logic [7:0] k,
                            input logic exp_found, input logic [7:0] exp_idx,
                            input int exp_edges, input int exp_cnt,
                            input bit hold_req);
    int n;
    bit got, we_seen;
    start = 1'b1; key = k;
    tick;
    if (hold_req) begin
      wr_en = 1'b1; wr_addr = 8'd42; wr_data = 8'h00;
    end else begin
      start = 1'b0;
    end
    check({tag, "_busy"}, busy, 1);
    n = 0; got = 0; we_seen = 0;
    while (!got && n < 400) begin
      tick;
      n++;
      if (ram_we) we_seen = 1;
      if (done) got = 1;
    end
    start = 1'b0; wr_en = 1'b0;
    check({tag, "_edges"}, got ? n : -1, exp_edges);
    check({tag, "_found"}, found, exp_found);
    check({tag, "_index"}, index, exp_idx);
    check({tag, "_no_we"}, we_seen, 0);
`ifdef LS_MATCH_COUNT_EN
    check({tag, "_cnt"}, match_cnt, exp_cnt);
`else
    if (exp_cnt < 0) $display("unexpected count argument");
`endif
    tick;
    check({tag, "_done_1cyc"}, done, 0);
    check({tag, "_idle"}, busy, 0);
    check({tag, "_hold_idx"}, index, exp_idx);
  endtask

  initial begin
    rst = 1'b1; wr_en = 1'b0; wr_addr = '0; wr_data = '0; start = 1'b0; key = '0;
    tick; tick;
    rst = 1'b0;
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_found", found, 0);
    check("rst_index", index, 0);
    check("rst_ce", ram_ce, 0);
    check("idle_addr", ram_addr, 0);
    check("idle_data", ram_data, 0);
`ifdef LS_MATCH_COUNT_EN
    check("rst_cnt", match_cnt, 0);
`endif

    // Write pass-through is combinational in the same cycle
    wr_en = 1'b1; wr_addr = 8'd0; wr_data = 8'd0;
    #1;
    check("wr_ce", ram_ce, 1);
    check("wr_we", ram_we, 1);
    for (int i = 0; i < 256; i++) load(8'(i), 8'(i));

    run_search("k2A", 8'h2A, 1, 8'd42, COUNT_MODE ? 257 : 44, 1, 0);
    run_search("kFF", 8'hFF, 1, 8'd255, 257, 1, 0);

    // Write wins over a same-cycle start
    wr_en = 1'b1; wr_addr = 8'd5; wr_data = 8'h77; start = 1'b1; key = 8'h77;
    #1;
    check("ws_we", ram_we, 1);
    check("ws_addr", ram_addr, 5);
    check("ws_data", ram_data, 8'h77);
    tick;
    wr_en = 1'b0; start = 1'b0;
    check("ws_busy", busy, 0);
    tick;
    check("ws_busy2", busy, 0);
    // mem[5] and mem[119] both hold 0x77; lowest wins
    run_search("k77", 8'h77, 1, 8'd5, COUNT_MODE ? 257 : 7, 2, 0);

    // Reset mid-scan aborts without a done pulse
    start = 1'b1; key = 8'h2A;
    tick;
    start = 1'b0;
    repeat (10) tick;
    check("ab_busy_pre", busy, 1);
    rst = 1'b1;
    tick;
    rst = 1'b0;
    check("ab_busy", busy, 0);
    check("ab_done", done, 0);
    check("ab_found", found, 0);
    check("ab_ce", ram_ce, 0);
    tick;
    check("ab_done2", done, 0);
    run_search("re2A", 8'h2A, 1, 8'd42, COUNT_MODE ? 257 : 44, 1, 1);

    // All-zero memory, miss
    for (int i = 0; i < 256; i++) load(8'(i), 8'h00);
    run_search("miss", 8'h01, 0, 8'd0, 257, 0, 0);

    // Three matching entries
    load(8'd3, 8'h55);
    load(8'd9, 8'h55);
    load(8'd200, 8'h55);
    run_search("k55", 8'h55, 1, 8'd3, COUNT_MODE ? 257 : 5, 3, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout");
    $fatal(1, "timeout");
  end

endmodule
